collision_event_scheduler: RTL and testbench
============================================

# collision_event_scheduler

Per-frame collision event scheduler for the Space Invaders video pipeline. During each frame it samples the per-pixel drawing requests of the player, enemy bomb, player shot, alien grid and borders, and latches one sticky flag per collision type. At each `startOfFrame` it snapshots those flags and dispatches them one at a time, in fixed priority, over a valid/ack handshake to the score/lives/projectile logic. It also owns the lives counter and the game-over state.

## Interface
Parameters:
- `NUM_LIVES`, default 3: initial lives; legal range 1..3.
- `ACK_TIMEOUT`, default 16: cycles an event is held without ack before it is dropped; legal range 2..255.

Ports:
- `clk` in 1: system clock.
- `resetN` in 1: asynchronous active-low reset.
- `startOfFrame` in 1: one-cycle pulse per frame.
- `drawing_request_smiley` in 1: player pixel active.
- `drawing_request_projectile` in 1: enemy bomb pixel active.
- `drawing_request_shot` in 1: player shot pixel active.
- `drawing_request_aliens` in 1: alien pixel active.
- `drawing_request_boarders` in 1: border pixel active.
- `event_ack` in 1: consumer accepts the current event.
- `event_valid` out 1: an event is presented.
- `event_code` out 2: 0 PLAYER_HIT, 1 ALIEN_HIT, 2 SHOT_LOST, 3 BOMB_LOST.
- `lives` out 2: remaining lives.
- `game_over` out 1: sticky, set when `lives` reaches 0.
- `event_dropped` out 1: one-cycle pulse when an event times out.
- `frame_overrun` out 1: one-cycle pulse when a frame starts while events are still pending.

## Operation
- **Collision terms** (combinational):
  - PLAYER_HIT = smiley & projectile.
  - ALIEN_HIT = shot & aliens.
  - SHOT_LOST = shot & boarders.
  - BOMB_LOST = projectile & boarders.
- **`sticky[3:0]`**: a bit is set on any cycle its term is true. Each type is captured at most once per frame, regardless of pixel count.
- **On `startOfFrame`**:
  - `pending <= pending | sticky`, then sticky is cleared.
  - A term true in the same cycle as `startOfFrame` sets the new frame's sticky bit, not the snapshot.
- **`frame_overrun`**: pulses if `pending` ≠ 0 or `event_valid` = 1 in the `startOfFrame` cycle. Pending events are merged, never lost.
- **FSM states**:
  - IDLE: `event_valid` = 0. If `pending` (after any load this cycle) ≠ 0, go to DISPATCH and register `event_code` = lowest set index.
  - DISPATCH: `event_valid` = 1, `event_code` stable, timeout counter running.
    - On `event_ack`: clear that pending bit and reset the counter. If other bits remain, stay in DISPATCH with the next lowest code; otherwise go to IDLE.
    - When the counter reaches `ACK_TIMEOUT`-1 without ack: clear the bit, pulse `event_dropped`, and advance as on ack.
  - GAME_OVER: `event_valid` = 0, `pending` and `sticky` held at 0, captures ignored. Exited only by reset.
- **Priority**: code 0 first. A higher-priority bit merged in while a lower event is being presented does not preempt it; it is taken at the next advance.
- **Lives**:
  - Decrement only on an acked PLAYER_HIT; a dropped PLAYER_HIT does not decrement.
  - Decrement is saturating at 0.
  - An acked PLAYER_HIT that takes `lives` from 1 to 0 sets `game_over` and moves the FSM to GAME_OVER on the same edge.
- **`event_ack`** while `event_valid` = 0 is ignored.

## Timing
- **Reset values**:
  - `event_valid` 0, `event_code` 0.
  - `lives` = `NUM_LIVES`.
  - `game_over` 0, `event_dropped` 0, `frame_overrun` 0.
  - `sticky`, `pending` 0; FSM in IDLE.
- **Reset mid-dispatch** clears everything immediately (asynchronous). No event is replayed.
- **All outputs are registered.**
- **Latency**: `startOfFrame` in cycle t with sticky ≠ 0 → `event_valid` = 1 in cycle t+1.
- **Handshake**:
  - Ack in cycle k → `event_valid` is either still 1 in k+1 with the next code (back-to-back), or 0.
  - Throughput is one event per cycle with ack tied high.
- **Timeout**: with no ack, `event_valid` is high for exactly `ACK_TIMEOUT` cycles. `event_dropped` pulses in the last of those cycles and the bit is cleared at its end.
- **Boundary**: ack in the same cycle the timeout would fire counts as an ack; no drop pulse.

## Test plan
- **Single hit, normal ack**: ALIEN_HIT overlap for 20 pixels in frame N, `event_ack` tied 1 → exactly one `event_valid` cycle, code 1, in the cycle after `startOfFrame`; `lives` = 3.
- **All four types in one frame, ack tied 1** → codes 0, 1, 2, 3 on consecutive cycles; `lives` 3→2.
- **Timeout, `ACK_TIMEOUT` = 16**: SHOT_LOST, ack held 0 → `event_valid` high 16 cycles, `event_dropped` pulses once, then `event_valid` = 0.
- **Overrun**: BOMB_LOST pending unacked, PLAYER_HIT captured, next `startOfFrame` → `frame_overrun` pulse. Code 3 is still presented until acked, then code 0 follows.
- **Game over, `NUM_LIVES` = 3**: three acked PLAYER_HITs in three frames → `lives` 2, 1, 0; `game_over` = 1 on the third ack. Later collisions produce no `event_valid`.
- **Reset mid-dispatch**: `resetN` low while `event_valid` = 1 → all outputs at reset values immediately; no event after release until a new collision plus `startOfFrame`.

Source files
------------

// File: rtl/collision_event_scheduler.sv
// collision_event_scheduler
// Captures one sticky flag per collision type during a frame. At each
// startOfFrame it merges those flags into a pending set. It then dispatches
// the pending events one at a time, lowest code first, over a valid/ack
// handshake. It also owns the lives counter and the game-over state.
//
// Ports:
//   clk, resetN                 clock, async active-low reset
//   startOfFrame                one-cycle pulse per frame
//   drawing_request_*           per-pixel draw requests of the sprites
//   event_ack                   consumer accepts the presented event
//   event_valid, event_code     presented event (0 PLAYER_HIT, 1 ALIEN_HIT,
//                               2 SHOT_LOST, 3 BOMB_LOST)
//   lives, game_over            remaining lives, sticky game-over flag
//   event_dropped               pulse in the last cycle of a timed-out event
//   frame_overrun               pulse when a frame starts with work pending
module collision_event_scheduler #(
  parameter int unsigned NUM_LIVES   = 3,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawing_request_smiley,
  input  logic       drawing_request_projectile,
  input  logic       drawing_request_shot,
  input  logic       drawing_request_aliens,
  input  logic       drawing_request_boarders,
  input  logic       event_ack,
  output logic       event_valid,
  output logic [1:0] event_code,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       event_dropped,
  output logic       frame_overrun
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned EVT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DISPATCH  = 2'd1,
    S_GAME_OVER = 2'd2
  } state_t;

  state_t             r_state;
  logic [EVT_W-1:0]   r_sticky;
  logic [EVT_W-1:0]   r_pending;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_valid;
  logic [1:0]         r_code;
  logic [1:0]         r_lives;
  logic               r_game_over;
  logic               r_dropped;
  logic               r_overrun;

  logic [EVT_W-1:0]   w_term;
  logic [EVT_W-1:0]   w_loaded;
  logic [EVT_W-1:0]   w_cur_bit;
  logic [EVT_W-1:0]   w_remain;
  logic               w_final;
  logic               w_hit_ack;
  logic [1:0]         w_lives_dec;

  // Lowest set index of an event set (code 0 has highest priority).
  function automatic logic [1:0] lowest_code(input logic [EVT_W-1:0] v);
    logic [1:0] c;
    c = 2'd3;
    if (v[2]) c = 2'd2;
    if (v[1]) c = 2'd1;
    if (v[0]) c = 2'd0;
    return c;
  endfunction

  // Collision terms, indexed by event code.
  assign w_term[0] = drawing_request_smiley & drawing_request_projectile;
  assign w_term[1] = drawing_request_shot   & drawing_request_aliens;
  assign w_term[2] = drawing_request_shot   & drawing_request_boarders;
  assign w_term[3] = drawing_request_projectile & drawing_request_boarders;

  // Pending set including this cycle's frame snapshot, and what is left
  // once the presented event retires.
  assign w_loaded    = r_pending | (startOfFrame ? r_sticky : {EVT_W{1'b0}});
  assign w_cur_bit   = EVT_W'(4'b0001 << r_code);
  assign w_remain    = w_loaded & ~w_cur_bit;
  assign w_final     = (r_cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign w_hit_ack   = event_ack & (r_code == 2'd0);
  assign w_lives_dec = (r_lives != 2'd0) ? (r_lives - 2'd1) : 2'd0;

  // Capture, snapshot and dispatch state machine.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state     <= S_IDLE;
      r_sticky    <= '0;
      r_pending   <= '0;
      r_cnt       <= '0;
      r_valid     <= 1'b0;
      r_code      <= 2'd0;
      r_lives     <= 2'(NUM_LIVES);
      r_game_over <= 1'b0;
      r_dropped   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_dropped <= 1'b0;
      r_overrun <= 1'b0;
      if (r_state != S_GAME_OVER) begin
        r_overrun <= startOfFrame & ((r_pending != '0) | r_valid);
        // A term coincident with startOfFrame belongs to the new frame.
        r_sticky  <= startOfFrame ? w_term : (r_sticky | w_term);
      end
      case (r_state)
        S_IDLE: begin
          r_pending <= w_loaded;
          if (w_loaded != '0) begin
            r_state <= S_DISPATCH;
            r_valid <= 1'b1;
            r_code  <= lowest_code(w_loaded);
            r_cnt   <= '0;
          end
        end
        S_DISPATCH: begin
          if (event_ack || w_final) begin
            if (w_hit_ack && (r_lives == 2'd1)) begin
              r_lives     <= 2'd0;
              r_game_over <= 1'b1;
              r_state     <= S_GAME_OVER;
              r_valid     <= 1'b0;
              r_pending   <= '0;
              r_sticky    <= '0;
              r_cnt       <= '0;
            end else begin
              if (w_hit_ack) r_lives <= w_lives_dec;
              r_pending <= w_remain;
              r_cnt     <= '0;
              if (w_remain != '0) begin
                r_code <= lowest_code(w_remain);
              end else begin
                r_state <= S_IDLE;
                r_valid <= 1'b0;
              end
            end
          end else begin
            r_pending <= w_loaded;
            r_cnt     <= r_cnt + CNT_W'(1);
            // Announce the drop during the final presented cycle.
            r_dropped <= ((r_cnt + CNT_W'(1)) == CNT_W'(ACK_TIMEOUT - 1));
          end
        end
        S_GAME_OVER: begin
          r_valid   <= 1'b0;
          r_pending <= '0;
          r_sticky  <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign event_valid   = r_valid;
  assign event_code    = r_code;
  assign lives         = r_lives;
  assign game_over     = r_game_over;
  assign event_dropped = r_dropped;
  assign frame_overrun = r_overrun;

endmodule

// File: tb/tb_collision_event_scheduler.sv
module tb_collision_event_scheduler;

  localparam int T_OUT = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       sof = 1'b0;
  logic       sm = 1'b0, pr = 1'b0, sh = 1'b0, al = 1'b0, bo = 1'b0;
  logic       ack = 1'b0;
  logic       event_valid;
  logic [1:0] event_code;
  logic [1:0] lives;
  logic       game_over;
  logic       event_dropped;
  logic       frame_overrun;

  int n_checks = 0;
  int n_pass   = 0;

  collision_event_scheduler #(.NUM_LIVES(3), .ACK_TIMEOUT(T_OUT)) dut (
    .clk                        (clk),
    .resetN                     (resetN),
    .startOfFrame               (sof),
    .drawing_request_smiley     (sm),
    .drawing_request_projectile (pr),
    .drawing_request_shot       (sh),
    .drawing_request_aliens     (al),
    .drawing_request_boarders   (bo),
    .event_ack                  (ack),
    .event_valid                (event_valid),
    .event_code                 (event_code),
    .lives                      (lives),
    .game_over                  (game_over),
    .event_dropped              (event_dropped),
    .frame_overrun              (frame_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic drive(input logic f, input logic a_sm, input logic a_pr,
                       input logic a_sh, input logic a_al, input logic a_bo,
                       input logic a_ack);
    sof = f; sm = a_sm; pr = a_pr; sh = a_sh; al = a_al; bo = a_bo; ack = a_ack;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       f, a_sm, a_pr, a_sh, a_al, a_bo, a_ack;
    logic       valid;
    logic [1:0] code;
    logic [1:0] lv;
    logic       over, drop, ovr;
  } vec_t;

  function automatic vec_t mk(input logic f, input logic a_sm, input logic a_pr,
                              input logic a_sh, input logic a_al, input logic a_bo,
                              input logic a_ack, input logic valid,
                              input logic [1:0] code, input logic [1:0] lv,
                              input logic over, input logic drop, input logic ovr);
    vec_t v;
    v.f = f; v.a_sm = a_sm; v.a_pr = a_pr; v.a_sh = a_sh; v.a_al = a_al;
    v.a_bo = a_bo; v.a_ack = a_ack; v.valid = valid; v.code = code; v.lv = lv;
    v.over = over; v.drop = drop; v.ovr = ovr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int       m_lives, m_code, m_age;
  bit       m_over, m_valid, m_dropped, m_overrun;
  bit [3:0] m_sticky, m_pending;

  function automatic int first_set(input bit [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_reset();
    m_lives = 3; m_code = 0; m_age = 0; m_over = 0; m_valid = 0;
    m_dropped = 0; m_overrun = 0; m_sticky = '0; m_pending = '0;
  endtask

  task automatic model_step(input bit f, input bit a_sm, input bit a_pr,
                            input bit a_sh, input bit a_al, input bit a_bo,
                            input bit a_ack);
    bit [3:0] t, set;
    t[0] = a_sm & a_pr; t[1] = a_sh & a_al; t[2] = a_sh & a_bo; t[3] = a_pr & a_bo;
    m_dropped = 0; m_overrun = 0;
    if (m_over) return;
    m_overrun = f && (m_pending != 0 || m_valid);
    set = m_pending | (f ? m_sticky : 4'b0000);
    m_sticky = f ? t : (m_sticky | t);
    if (!m_valid) begin
      m_pending = set;
      if (set != 0) begin m_valid = 1; m_code = first_set(set); m_age = 0; end
    end else if (a_ack || m_age == T_OUT - 1) begin
      if (a_ack && m_code == 0) begin
        if (m_lives > 0) m_lives = m_lives - 1;
        if (m_lives == 0) begin
          m_over = 1; m_valid = 0; m_pending = '0; m_sticky = '0;
          return;
        end
      end
      set[m_code] = 1'b0;
      m_pending = set;
      if (set != 0) begin m_code = first_set(set); m_age = 0; end
      else m_valid = 0;
    end else begin
      m_age = m_age + 1;
      m_pending = set;
      m_dropped = (m_age == T_OUT - 1);
    end
  endtask

  initial begin : main
    vec_t tbl[11];
    int vcnt, dcnt, last_v, drop_i, seg_ack;
    bit r_f, r_sm, r_pr, r_sh, r_al, r_bo, r_ack;

    // Reset state
    do_reset();
    check("rst_valid", int'(event_valid), 0);
    check("rst_code", int'(event_code), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_over", int'(game_over), 0);
    check("rst_drop", int'(event_dropped), 0);
    check("rst_ovr", int'(frame_overrun), 0);

    // Single ALIEN_HIT, then all four types with ack tied high
    tbl[0]  = mk(0,0,0,0,0,0,1, 0,2'd0,2'd3,0,0,0);
    tbl[1]  = mk(0,0,0,1,1,0,1, 0,2'd0,2'd3,0,0,0);
    tbl[2]  = mk(0,0,0,1,1,0,1, 0,2'd0,2'd3,0,0,0);
    tbl[3]  = mk(1,0,0,0,0,0,1, 1,2'd1,2'd3,0,0,0);
    tbl[4]  = mk(0,0,0,0,0,0,1, 0,2'd0,2'd3,0,0,0);
    tbl[5]  = mk(0,1,1,1,1,1,1, 0,2'd0,2'd3,0,0,0);
    tbl[6]  = mk(1,0,0,0,0,0,1, 1,2'd0,2'd3,0,0,0);
    tbl[7]  = mk(0,0,0,0,0,0,1, 1,2'd1,2'd2,0,0,0);
    tbl[8]  = mk(0,0,0,0,0,0,1, 1,2'd2,2'd2,0,0,0);
    tbl[9]  = mk(0,0,0,0,0,0,1, 1,2'd3,2'd2,0,0,0);
    tbl[10] = mk(0,0,0,0,0,0,1, 0,2'd0,2'd2,0,0,0);
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].f, tbl[i].a_sm, tbl[i].a_pr, tbl[i].a_sh, tbl[i].a_al,
            tbl[i].a_bo, tbl[i].a_ack);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), int'(event_valid), int'(tbl[i].valid));
      if (tbl[i].valid) check($sformatf("vec%0d_code", i), int'(event_code), int'(tbl[i].code));
      check($sformatf("vec%0d_lives", i), int'(lives), int'(tbl[i].lv));
      check($sformatf("vec%0d_over", i), int'(game_over), int'(tbl[i].over));
      check($sformatf("vec%0d_drop", i), int'(event_dropped), int'(tbl[i].drop));
      check($sformatf("vec%0d_ovr", i), int'(frame_overrun), int'(tbl[i].ovr));
    end

    // Timeout: SHOT_LOST, never acked
    do_reset();
    drive(0,0,0,1,0,1,0); @(negedge clk);
    drive(1,0,0,0,0,0,0); @(negedge clk);
    drive(0,0,0,0,0,0,0);
    vcnt = 0; dcnt = 0; last_v = -1; drop_i = -2;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (event_valid) begin vcnt++; last_v = i; end
      if (event_dropped) begin dcnt++; drop_i = i; end
      if (i == 0) check("to_code", int'(event_code), 2);
    end
    check("to_valid_cycles", vcnt, T_OUT);
    check("to_drop_pulses", dcnt, 1);
    check("to_drop_in_last", drop_i, last_v);
    check("to_valid_after", int'(event_valid), 0);
    check("to_lives", int'(lives), 3);

    // Overrun: BOMB_LOST unacked while PLAYER_HIT captured in next frame
    do_reset();
    drive(0,0,1,0,0,1,0); @(negedge clk);
    drive(1,0,0,0,0,0,0); @(negedge clk);
    check("ov_first_code", int'(event_code), 3);
    drive(0,1,1,0,0,0,0); @(negedge clk);
    drive(1,0,0,0,0,0,0); @(negedge clk);
    check("ov_pulse", int'(frame_overrun), 1);
    check("ov_still_valid", int'(event_valid), 1);
    check("ov_still_code3", int'(event_code), 3);
    drive(0,0,0,0,0,0,1); @(negedge clk);
    check("ov_pulse_gone", int'(frame_overrun), 0);
    check("ov_next_valid", int'(event_valid), 1);
    check("ov_next_code0", int'(event_code), 0);
    check("ov_lives_kept", int'(lives), 3);
    @(negedge clk);
    check("ov_lives_dec", int'(lives), 2);
    check("ov_idle", int'(event_valid), 0);
    check("ov_no_drop", int'(event_dropped), 0);

    // Game over after three acked PLAYER_HITs
    do_reset();
    for (int f = 0; f < 3; f++) begin
      drive(0,1,1,0,0,0,0); @(negedge clk);
      drive(1,0,0,0,0,0,1); @(negedge clk);
      check($sformatf("go%0d_code", f), int'(event_code), 0);
      drive(0,0,0,0,0,0,1); @(negedge clk);
      check($sformatf("go%0d_lives", f), int'(lives), 2 - f);
      check($sformatf("go%0d_over", f), int'(game_over), (f == 2) ? 1 : 0);
      check($sformatf("go%0d_valid", f), int'(event_valid), 0);
    end
    vcnt = 0;
    for (int i = 0; i < 24; i++) begin
      drive((i % 8) == 7, 1, 1, 1, 1, 1, 1);
      @(negedge clk);
      if (event_valid) vcnt++;
    end
    check("go_no_events", vcnt, 0);
    check("go_sticky", int'(game_over), 1);
    check("go_lives_zero", int'(lives), 0);

    // Reset while an event is presented
    do_reset();
    drive(0,0,0,1,1,0,0); @(negedge clk);
    drive(1,0,0,0,0,0,0); @(negedge clk);
    check("rm_valid_before", int'(event_valid), 1);
    drive(0,0,0,0,0,0,0);
    #2 resetN = 1'b0;
    #1;
    check("rm_valid", int'(event_valid), 0);
    check("rm_code", int'(event_code), 0);
    check("rm_lives", int'(lives), 3);
    check("rm_over", int'(game_over), 0);
    @(negedge clk); @(negedge clk);
    resetN = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      drive((i % 4) == 3, 0, 0, 0, 0, 0, 1);
      @(negedge clk);
      if (event_valid) vcnt++;
    end
    check("rm_no_replay", vcnt, 0);
    drive(0,0,0,1,1,0,0); @(negedge clk);
    drive(1,0,0,0,0,0,0); @(negedge clk);
    check("rm_new_event", int'(event_valid), 1);
    check("rm_new_code", int'(event_code), 1);

    // Randomized run against the reference model
    for (int seg = 0; seg < 12; seg++) begin
      do_reset();
      model_reset();
      seg_ack = (seg % 3 == 0) ? 90 : ((seg % 3 == 1) ? 30 : 3);
      for (int c = 0; c < 250; c++) begin
        r_f   = ($urandom_range(0, 15) == 0);
        r_sm  = ($urandom_range(0, 3) == 0);
        r_pr  = ($urandom_range(0, 3) == 0);
        r_sh  = ($urandom_range(0, 3) == 0);
        r_al  = ($urandom_range(0, 3) == 0);
        r_bo  = ($urandom_range(0, 3) == 0);
        r_ack = ($urandom_range(0, 99) < seg_ack);
        drive(r_f, r_sm, r_pr, r_sh, r_al, r_bo, r_ack);
        model_step(r_f, r_sm, r_pr, r_sh, r_al, r_bo, r_ack);
        @(negedge clk);
        check("rnd_valid", int'(event_valid), int'(m_valid));
        if (m_valid) check("rnd_code", int'(event_code), m_code);
        check("rnd_lives", int'(lives), m_lives);
        check("rnd_over", int'(game_over), int'(m_over));
        check("rnd_drop", int'(event_dropped), int'(m_dropped));
        check("rnd_ovr", int'(frame_overrun), int'(m_overrun));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
